// File: rtl/riscv_hpm_unit_pkg.sv
// Shared CSR operation codes and HPM address map for the performance-monitor unit.
// csr_apply gives the value a CSR holds after a WRITE/SET/CLEAR/NONE operation.
package riscv_hpm_unit_pkg;

    localparam logic [1:0] CSR_OP_NONE  = 2'b00;
    localparam logic [1:0] CSR_OP_WRITE = 2'b01;
    localparam logic [1:0] CSR_OP_SET   = 2'b10;
    localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

    localparam logic [11:0] HPM_EVSEL_BASE = 12'h780;
    localparam logic [11:0] HPM_CNTLO_BASE = 12'h790;
    localparam logic [11:0] HPM_CNTHI_BASE = 12'h798;
    localparam logic [11:0] HPM_CTRL       = 12'h7A0;
    localparam logic [11:0] HPM_OVF        = 12'h7A2;
    localparam logic [11:0] HPM_OVFIE      = 12'h7A3;

    function automatic logic [31:0] csr_apply(input logic [1:0]  op,
                                              input logic [31:0] old,
                                              input logic [31:0] wdata);
        logic [31:0] res;
        res = old;
        case (op)
            CSR_OP_WRITE: res = wdata;
            CSR_OP_SET:   res = old | wdata;
            CSR_OP_CLEAR: res = old & ~wdata;
            default:      res = old;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/riscv_hpm_unit_counter.sv
// One HPM counter slice: registered increment request, counter, upper-word shadow
// and the wrap/saturate overflow pulse.
module riscv_hpm_counter #(
    parameter int unsigned CNT_WIDTH = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_i,
    input  logic                 saturate_i,
    input  logic                 wr_lo_i,
    input  logic                 wr_hi_i,
    input  logic                 capture_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          count_lo_o,
    output logic [CNT_WIDTH-33:0] shadow_o,
    output logic                 ovf_o
);

    localparam int unsigned HiW = CNT_WIDTH - 32;

    logic                 inc_q;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [HiW-1:0]       shadow_q, shadow_d;

    always_comb begin
        count_d  = count_q;
        shadow_d = shadow_q;
        ovf_o    = 1'b0;
        // A software write to either half drops the increment of that cycle.
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) count_d[31:0] = wdata_i;
            if (wr_hi_i) count_d[CNT_WIDTH-1:32] = wdata_i[HiW-1:0];
        end else if (inc_q) begin
            if (&count_q) begin
                ovf_o = 1'b1;
                if (!saturate_i) count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
        if (wr_hi_i) begin
            shadow_d = wdata_i[HiW-1:0];
        end else if (capture_i) begin
            shadow_d = count_q[CNT_WIDTH-1:32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_q    <= 1'b0;
            count_q  <= '0;
            shadow_q <= '0;
        end else begin
            inc_q    <= sample_i;
            count_q  <= count_d;
            shadow_q <= shadow_d;
        end
    end

    assign count_lo_o = count_q[31:0];
    assign shadow_o   = shadow_q;

endmodule

// File: rtl/riscv_hpm_unit.sv
// Parametrised performance-monitor unit: CSR decode, read mux, event selection,
// control/overflow registers and N_CNT counter slices.
module riscv_hpm_unit
    import riscv_hpm_unit_pkg::*;
#(
    parameter int unsigned N_CNT     = 4,
    parameter int unsigned CNT_WIDTH = 48,
    parameter int unsigned N_EVENTS  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                csr_access_i,
    input  logic [11:0]         csr_addr_i,
    input  logic [31:0]         csr_wdata_i,
    input  logic [1:0]          csr_op_i,
    output logic [31:0]         csr_rdata_o,
    output logic                csr_hit_o,
    input  logic [N_EVENTS-1:0] events_i,
    input  logic                halt_i,
    output logic                ovf_irq_o
);

    localparam int unsigned EV_BITS = $clog2(N_EVENTS);
    localparam int unsigned EvSpan  = 1 << EV_BITS;
    localparam int unsigned HiW     = CNT_WIDTH - 32;

    logic [N_CNT-1:0]   evsel_en_q;
    logic [EV_BITS-1:0] evsel_idx_q [N_CNT];
    logic [1:0]         ctrl_q, ctrl_d;
    logic [N_CNT-1:0]   ovf_q, ovf_d, ovfie_q, ovfie_d;

    logic [N_CNT-1:0]   sel_evsel, sel_lo, sel_hi, sample, ovf_pulse;
    logic               sel_ctrl, sel_ovf, sel_ovfie, we;
    logic [31:0]        rdata_raw, wnew;
    logic [31:0]        count_lo [N_CNT];
    logic [HiW-1:0]     shadow   [N_CNT];
    logic [EvSpan-1:0]  events_ext;

    // Indices beyond N_EVENTS land on the zero-extended padding.
    assign events_ext = EvSpan'(events_i);

    always_comb begin
        sel_evsel = '0;
        sel_lo    = '0;
        sel_hi    = '0;
        sample    = '0;
        for (int i = 0; i < N_CNT; i++) begin
            sel_evsel[i] = (csr_addr_i == HPM_EVSEL_BASE + 12'(i));
            sel_lo[i]    = (csr_addr_i == HPM_CNTLO_BASE + 12'(i));
            sel_hi[i]    = (csr_addr_i == HPM_CNTHI_BASE + 12'(i));
            sample[i]    = ctrl_q[0] & ~halt_i & evsel_en_q[i] & events_ext[evsel_idx_q[i]];
        end
        sel_ctrl  = (csr_addr_i == HPM_CTRL);
        sel_ovf   = (csr_addr_i == HPM_OVF);
        sel_ovfie = (csr_addr_i == HPM_OVFIE);
    end

    assign csr_hit_o = csr_access_i &
                       (|sel_evsel | |sel_lo | |sel_hi | sel_ctrl | sel_ovf | sel_ovfie);
    assign we        = csr_access_i & (csr_op_i != CSR_OP_NONE);

    always_comb begin
        rdata_raw = '0;
        for (int i = 0; i < N_CNT; i++) begin
            if (sel_evsel[i]) rdata_raw = {evsel_en_q[i], 31'(evsel_idx_q[i])};
            if (sel_lo[i])    rdata_raw = count_lo[i];
            if (sel_hi[i])    rdata_raw = 32'(shadow[i]);
        end
        if (sel_ctrl)  rdata_raw = 32'(ctrl_q);
        if (sel_ovf)   rdata_raw = 32'(ovf_q);
        if (sel_ovfie) rdata_raw = 32'(ovfie_q);
    end

    // The read value doubles as the old value, so unimplemented bits stay zero.
    assign wnew        = csr_apply(csr_op_i, rdata_raw, csr_wdata_i);
    assign csr_rdata_o = csr_hit_o ? rdata_raw : '0;

    always_comb begin
        ctrl_d  = (we && sel_ctrl)  ? wnew[1:0]       : ctrl_q;
        ovfie_d = (we && sel_ovfie) ? wnew[N_CNT-1:0] : ovfie_q;
        ovf_d   = ((we && sel_ovf)  ? wnew[N_CNT-1:0] : ovf_q) | ovf_pulse;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= 2'b01;
            ovf_q      <= '0;
            ovfie_q    <= '0;
            evsel_en_q <= '0;
            for (int i = 0; i < N_CNT; i++) evsel_idx_q[i] <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            ovf_q   <= ovf_d;
            ovfie_q <= ovfie_d;
            for (int i = 0; i < N_CNT; i++) begin
                if (we && sel_evsel[i]) begin
                    evsel_en_q[i]  <= wnew[31];
                    evsel_idx_q[i] <= wnew[EV_BITS-1:0];
                end
            end
        end
    end

    assign ovf_irq_o = |(ovf_q & ovfie_q);

    for (genvar g = 0; g < N_CNT; g++) begin : g_cnt
        riscv_hpm_counter #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .sample_i   (sample[g]),
            .saturate_i (ctrl_q[1]),
            .wr_lo_i    (we & sel_lo[g]),
            .wr_hi_i    (we & sel_hi[g]),
            .capture_i  (csr_access_i & sel_lo[g]),
            .wdata_i    (wnew),
            .count_lo_o (count_lo[g]),
            .shadow_o   (shadow[g]),
            .ovf_o      (ovf_pulse[g])
        );
    end

endmodule

// File: doc/riscv_hpm_unit.md
# riscv_hpm_unit

Parametrised hardware performance-monitor unit for the RI5CY core. It generalises the fixed 32-bit, one-counter-per-event scheme to N_CNT counters of CNT_WIDTH bits, each bound to any of N_EVENTS event lines. It adds tear-free reads of the upper word, wrap or saturate modes, per-counter overflow status and a maskable overflow interrupt. It sits beside the CSR file, shares its CSR access port and returns read data through csr_hit_o.

## Interface
- N_CNT, 4: number of counters, 1..8.
- CNT_WIDTH, 48: counter width, 33..64.
- N_EVENTS, 16: event input lines, 2..32; EV_BITS = $clog2(N_EVENTS).
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- csr_access_i  in  1  CSR instruction in EX; qualifies every access.
- csr_addr_i  in  12  CSR address.
- csr_wdata_i  in  32  operand.
- csr_op_i  in  2  CSR_OP_NONE/WRITE/SET/CLEAR.
- csr_rdata_o  out  32  read data; 0 when csr_hit_o=0.
- csr_hit_o  out  1  address decodes to this unit (and csr_access_i=1).
- events_i  in  N_EVENTS  event lines, 1 = one occurrence this cycle.
- halt_i  in  1  debug halt; freezes counting.
- ovf_irq_o  out  1  |(OVF & OVFIE).

## Operation
- Address map:
  - 0x780+i EVSEL[i]: bit31 enable, [EV_BITS-1:0] event index.
  - 0x790+i CNT_LO[i]: bits 31:0.
  - 0x798+i CNT_HI[i]: bits CNT_WIDTH-1:32, zero-extended.
  - 0x7A0 CTRL: bit0 global enable, bit1 saturate (0 = wrap).
  - 0x7A2 OVF: status[N_CNT-1:0].
  - 0x7A3 OVFIE: mask[N_CNT-1:0].
  - Counter slots i ≥ N_CNT and unlisted addresses: no hit, read 0, write ignored.
- CSR ops: WRITE new = wdata; SET new = old | wdata; CLEAR new = old & ~wdata; NONE = read only. Unimplemented bits read 0 and ignore writes.
- Event sampling: inc_q[i] <= CTRL[0] & ~halt_i & EVSEL[i][31] & events_i[EVSEL[i] index]. An index ≥ N_EVENTS samples 0.
- Counting: if inc_q[i], counter +1.
  - At all-ones in wrap mode: goes to 0 and sets OVF[i].
  - At all-ones in saturate mode: holds all-ones and sets OVF[i] on every saturated increment.
- Tear-free read: reading CNT_LO[i] (any op, csr_access_i=1) captures counter[i][CNT_WIDTH-1:32] into shadow[i] at the edge. CNT_HI[i] reads return shadow[i]. Writes to CNT_HI also update shadow[i].
- Simultaneous events:
  - A software write to CNT_LO/CNT_HI in the same cycle as inc_q wins; that increment is dropped.
  - A hardware OVF set wins over a software CLEAR of the same bit in the same cycle.
  - An EVSEL change affects sampling from the next cycle.
- Reset values: counters, shadows, inc_q, EVSEL, OVF, OVFIE = 0; CTRL = 0x1 (enabled, wrap). csr_rdata_o = 0, csr_hit_o = 0, ovf_irq_o = 0. Reset mid-operation discards pending inc_q.

## Timing
- Reads are combinational; csr_rdata_o is valid in the same cycle as csr_access_i.
- CSR writes are visible from the cycle after the edge.
- Event latency: events_i high in cycle t → inc_q set at edge t+1 → counter +1 at edge t+2.
- halt_i in cycle t suppresses events of cycle t only; increments already in inc_q still complete.
- ovf_irq_o rises in the cycle after the overflowing edge (registered OVF, combinational AND).
- One increment per counter per cycle maximum.

## Structure
- Address constants (HPM_EVSEL_BASE, HPM_CNTLO_BASE, HPM_CNTHI_BASE, HPM_CTRL, HPM_OVF, HPM_OVFIE) go in riscv_defines next to CSR_OP_*.
- Sub-module riscv_hpm_counter holds one slice: inc_q, counter, shadow, and the wrap/saturate/overflow pulse. It is instantiated N_CNT times via generate.
- Decode, the read mux, CTRL, OVF and OVFIE live in the top.

## Test plan
- Reset → all CSRs read 0 except CTRL = 0x1; ovf_irq_o = 0.
- EVSEL[0] = 0x80000003, events_i[3] pulsed 5 single cycles → CNT_LO[0] = 5 two cycles after the last pulse; halt_i held during 2 extra pulses → still 5.
- CNT_HI[1] = 0xFFFF, CNT_LO[1] = 0xFFFFFFFE, EVSEL[1] enabled, event held for 2 cycles:
  - wrap mode → counter 0 and OVF = 0x2; with OVFIE = 0x2, ovf_irq_o = 1 one cycle later.
  - saturate mode → counter holds 0xFFFF_FFFFFFFF.
- Tear-free read: counter at 0x0_FFFFFFFF; read CNT_LO, increment occurs, read CNT_HI → 0, not 1; a following CNT_LO read then CNT_HI read → 1.
- CSR CLEAR of OVF bit 0 in the same cycle as a counter 0 overflow → OVF[0] stays 1; CNT_LO write 0x10 coincident with inc_q → reads 0x10.
- Access to 0x794 with N_CNT = 4 → csr_hit_o = 0, rdata 0, no state change.
